// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer pixel writer.
// Defining PIXEL_RGB565_EN narrows the stored pixel from RGB888 to RGB565.
package fb_pkg;
  localparam int H_RES_DEFAULT = 320;
  localparam int V_RES_DEFAULT = 180;

`ifdef PIXEL_RGB565_EN
  localparam int PIX_W = 16;
`else
  localparam int PIX_W = 24;
`endif

  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} fb_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Plain truncation of the low bits of each channel.
  function automatic logic [15:0] rgb888_to_565(input rgb888_t p);
    return {p.r[7:3], p.g[7:2], p.b[7:3]};
  endfunction
endpackage

// File: rtl/fb_addr_gen.sv
// Two-stage address arithmetic: S1 holds the counts, range flags and row base,
// S2 holds the linear frame-buffer address of the pixel being written.
module fb_addr_gen import fb_pkg::*; #(
  parameter int H_RES  = H_RES_DEFAULT,
  parameter int V_RES  = V_RES_DEFAULT,
  parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              take,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic              in_range,
  output logic              origin,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);

  logic [10:0]       s1_h;
  logic [9:0]        s1_v;
  logic [ADDR_W-1:0] s1_row_base;

  // load captures a newly accepted pixel; take moves a to-be-written pixel into S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_h        <= '0;
      s1_v        <= '0;
      s1_row_base <= '0;
    end else if (load) begin
      s1_h        <= hcount;
      s1_v        <= vcount;
      s1_row_base <= ADDR_W'(32'(vcount) * H_RES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (take) begin
      addr <= s1_row_base + ADDR_W'(s1_h);
    end
  end

  assign in_range = (s1_h < H_LIM) && (s1_v < V_LIM);
  assign origin   = (s1_h == 11'd0) && (s1_v == 10'd0);
  assign last     = (s1_h == H_LIM - 11'd1) && (s1_v == V_LIM - 10'd1);
endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-start aligned pixel writer from the renderer stream into a BRAM write port.
// PIXEL_RGB565_EN selects RGB565 storage; otherwise tdata is stored unchanged.
module fb_pixel_writer import fb_pkg::*; #(
  parameter int H_RES  = H_RES_DEFAULT,
  parameter int V_RES  = V_RES_DEFAULT,
  parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [23:0]       pixel_axis_tdata,
  input  logic              pixel_axis_tvalid,
  output logic              pixel_axis_tready,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count,
  output fb_state_t         fsm_state
);
  fb_state_t        state, state_d;
  logic             s1_valid;
  logic [23:0]      s1_data;
  logic [PIX_W-1:0] s1_pix;
  logic             s2_last;
  logic             s1_adv, accept, decide, s1_write, s1_drop;
  logic             in_range, origin, last;

  // A pixel transfers when tvalid & tready; tready depends only on pipeline
  // occupancy and fb_ready (never on tvalid), and is held low while in reset.
  assign s1_adv            = !fb_we || fb_ready;
  assign pixel_axis_tready = !areset && (!s1_valid || s1_adv);
  assign accept            = pixel_axis_tvalid && pixel_axis_tready;
  assign decide            = s1_valid && s1_adv;
  assign frame_done        = fb_we && fb_ready && s2_last;
  assign fsm_state         = state;

`ifdef PIXEL_RGB565_EN
  assign s1_pix = rgb888_to_565(rgb888_t'(s1_data));
`else
  assign s1_pix = s1_data;
`endif

  fb_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (aclk),
    .rst      (areset),
    .load     (accept),
    .take     (s1_write),
    .hcount   (hcount_in),
    .vcount   (vcount_in),
    .in_range (in_range),
    .origin   (origin),
    .last     (last),
    .addr     (fb_addr)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= SYNC;
    else        state <= state_d;
  end

  // Each S1 pixel is classified once, in the cycle it leaves S1.
  always_comb begin
    state_d  = state;
    s1_write = 1'b0;
    s1_drop  = 1'b0;
    if (decide) begin
      case (state)
        SYNC: begin
          if (origin && enable) begin
            s1_write = 1'b1;
            state_d  = ACTIVE;
          end
        end
        ACTIVE: begin
          s1_write = in_range;
          s1_drop  = !in_range;
          if (!enable) state_d = SYNC;
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      fb_we    <= 1'b0;
      fb_data  <= '0;
      s2_last  <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= pixel_axis_tdata;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) fb_we <= s1_write;
      if (s1_write) begin
        fb_data <= s1_pix;
        s2_last <= last;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (s1_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer on a 4x2 frame: vector table, directed sequences
// for backpressure/enable/reset, and a write scoreboard keyed on {frame_done, addr, data}.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;
  localparam int EW = 1 + AW + PIX_W;

  typedef struct {
    logic [10:0]   h;
    logic [9:0]    v;
    logic [23:0]   d;
    logic          wr;
    logic [AW-1:0] addr;
    logic          last;
  } vec_t;

  logic              aclk = 1'b0;
  logic              areset = 1'b0;
  logic              enable = 1'b1;
  logic [23:0]       tdata = '0;
  logic              tvalid = 1'b0;
  logic              tready;
  logic [10:0]       hcount = '0;
  logic [9:0]        vcount = '0;
  logic [AW-1:0]     fb_addr;
  logic [PIX_W-1:0]  fb_data;
  logic              fb_we;
  logic              fb_ready = 1'b1;
  logic              frame_done;
  logic [15:0]       frame_count, drop_count;
  fb_state_t         fsm_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int acc_cyc = -1;
  int lat_acc = -1;
  int first_wr_cyc = -1;
  bit sending = 1'b0;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[12];

  fb_pixel_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .enable            (enable),
    .pixel_axis_tdata  (tdata),
    .pixel_axis_tvalid (tvalid),
    .pixel_axis_tready (tready),
    .hcount_in         (hcount),
    .vcount_in         (vcount),
    .fb_addr           (fb_addr),
    .fb_data           (fb_data),
    .fb_we             (fb_we),
    .fb_ready          (fb_ready),
    .frame_done        (frame_done),
    .frame_count       (frame_count),
    .drop_count        (drop_count),
    .fsm_state         (fsm_state)
  );

  // clock / cycle counter
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [PIX_W-1:0] exp_pix(input logic [23:0] d);
`ifdef PIXEL_RGB565_EN
    return {d[23:19], d[15:10], d[7:3]};
`else
    return d;
`endif
  endfunction

  function automatic vec_t mk(input int h, input int v, input bit wr, input int a, input bit last);
    vec_t r;
    r.h = 11'(h); r.v = 10'(v); r.wr = wr; r.addr = AW'(a); r.last = last;
    r.d = 24'($urandom);
    return r;
  endfunction

  task automatic push_exp(input logic last, input logic [AW-1:0] a, input logic [23:0] d);
    exp_q.push_back({last, a, exp_pix(d)});
  endtask

  // driver: present one pixel and hold it until accepted (bounded)
  task automatic send_pixel(input logic [10:0] h, input logic [9:0] v, input logic [23:0] d);
    bit ok = 1'b0;
    tvalid = 1'b1; hcount = h; vcount = v; tdata = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge aclk);
      if (tready) ok = 1'b1;
    end
    if (ok) acc_cyc = cyc;
    else begin
      total_cnt++;
      $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted within 100 cycles", h, v);
    end
    @(posedge aclk); #1;
    tvalid = 1'b0;
  endtask

  task automatic send_frame();
    logic [23:0] d;
    for (int i = 0; i < H * V; i++) begin
      d = 24'($urandom);
      push_exp(i == H * V - 1, AW'(i), d);
      send_pixel(11'(i % H), 10'(i / H), d);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(2, 0, 0, 0, 0);
    vecs[1]  = mk(3, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0);
    vecs[2].d = 24'hFF8040;
    vecs[3]  = mk(1, 0, 1, 1, 0);
    vecs[4]  = mk(2, 0, 1, 2, 0);
    vecs[5]  = mk(3, 0, 1, 3, 0);
    vecs[6]  = mk(0, 1, 1, 4, 0);
    vecs[7]  = mk(1, 1, 1, 5, 0);
    vecs[8]  = mk(2, 1, 1, 6, 0);
    vecs[9]  = mk(3, 1, 1, 7, 1);
    vecs[10] = mk(4, 0, 0, 0, 0);
    vecs[11] = mk(0, 2, 0, 0, 0);

    // reset
    #1 areset = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_fb_we", 64'(fb_we), 64'd0);
    check("rst_fb_addr", 64'(fb_addr), 64'd0);
    check("rst_fb_data", 64'(fb_data), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_tready", 64'(tready), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(SYNC));
    areset = 1'b0;
    #1 check("tready_after_reset", 64'(tready), 64'd1);

    // scoreboard monitor
    fork
      forever begin
        @(negedge aclk);
        if (!areset) begin
          if (fb_we && fb_ready) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
              total_cnt++;
              $display("FAIL unexpected_write: addr %0d data 0x%0h, nothing expected", fb_addr, fb_data);
            end else begin
              check("write", 64'({frame_done, fb_addr, fb_data}), 64'(exp_q.pop_front()));
            end
          end else if (frame_done) begin
            total_cnt++;
            $display("FAIL frame_done_no_write: got 1 expected 0 (cycle %0d)", cyc);
          end
        end
      end
    join_none
    drain(1);

    // sync, full frame and out-of-range, back-to-back
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) push_exp(vecs[i].last, vecs[i].addr, vecs[i].d);
      send_pixel(vecs[i].h, vecs[i].v, vecs[i].d);
      if (i == 2) begin
        lat_acc = acc_cyc;
        check("sync_no_drop", 64'(drop_count), 64'd0);
      end
    end
    drain(6);
    check("first_write_latency", 64'(first_wr_cyc - lat_acc), 64'd2);
    check("oor_drop_count", 64'(drop_count), 64'd2);
    check("frame_count_1", 64'(frame_count), 64'd1);
    check("state_active", 64'(fsm_state), 64'(ACTIVE));
    check("queue_empty_1", 64'(exp_q.size()), 64'd0);

    // backpressure: 5-cycle fb_ready stall mid-frame
    fork
      send_frame();
      begin
        repeat (3) @(posedge aclk);
        #1 fb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge aclk);
          if (k == 1) check("tready_stall", 64'(tready), 64'd0);
          if (k == 4) begin
            check("we_hold", 64'(fb_we), 64'd1);
            check("addr_hold", 64'(fb_addr), 64'd1);
          end
        end
        @(posedge aclk);
        #1 fb_ready = 1'b1;
      end
    join
    drain(6);
    check("frame_count_2", 64'(frame_count), 64'd2);
    check("queue_empty_2", 64'(exp_q.size()), 64'd0);

    // enable drops at (1,1): that pixel completes, rest of frame ignored
    for (int i = 0; i < 5; i++) begin
      logic [23:0] d;
      d = 24'($urandom);
      push_exp(1'b0, AW'(i), d);
      send_pixel(11'(i % H), 10'(i / H), d);
    end
    drain(4);
    enable = 1'b0;
    begin
      logic [23:0] d;
      d = 24'($urandom);
      push_exp(1'b0, AW'(5), d);
      send_pixel(11'd1, 10'd1, d);
    end
    send_pixel(11'd2, 10'd1, 24'($urandom));
    send_pixel(11'd3, 10'd1, 24'($urandom));
    drain(4);
    check("partial_frame_count", 64'(frame_count), 64'd2);
    check("disable_state", 64'(fsm_state), 64'(SYNC));
    check("disable_no_drop", 64'(drop_count), 64'd2);
    enable = 1'b1;
    send_frame();
    drain(4);
    check("frame_count_3", 64'(frame_count), 64'd3);
    check("reenable_state", 64'(fsm_state), 64'(ACTIVE));

    // random backpressure frame
    sending = 1'b1;
    fork
      begin
        send_frame();
        sending = 1'b0;
      end
      while (sending) begin
        @(posedge aclk);
        #1 fb_ready = ($urandom_range(0, 3) != 0);
      end
    join
    fb_ready = 1'b1;
    drain(6);
    check("frame_count_4", 64'(frame_count), 64'd4);
    check("queue_empty_3", 64'(exp_q.size()), 64'd0);

    // reset while a write is pending
    fb_ready = 1'b0;
    send_pixel(11'd0, 10'd0, 24'($urandom));
    drain(3);
    check("pending_we", 64'(fb_we), 64'd1);
    #2 areset = 1'b1;
    #1;
    check("async_we_clear", 64'(fb_we), 64'd0);
    check("async_tready", 64'(tready), 64'd0);
    check("async_frame_count", 64'(frame_count), 64'd0);
    check("async_drop_count", 64'(drop_count), 64'd0);
    check("async_state", 64'(fsm_state), 64'(SYNC));
    @(negedge aclk);
    areset = 1'b0;
    fb_ready = 1'b1;
    drain(4);
    check("post_reset_no_write", 64'(fb_we), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
